mux_scan_ctrl: RTL and testbench

//  Upstream sequencer for the 13:1 bit mux. Drives its 4-bit select, waits a settle

---
 rtl/mux_scan_ctrl.sv | 117 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 13:1 bit mux: steps the select through the enabled channels,
// samples one bit per channel after a settle time and hands out frames via valid/ready.
module mux_scan_ctrl #(
    parameter int NUM_CH = 13,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] chan_mask,
    input  logic              cont_mode,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_y,
    output logic [NUM_CH-1:0] frame_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy
);

    localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;

    state_t            state;
    logic [SEL_W-1:0]  ch;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] shadow;
    logic [SEL_W:0]    first_hit;
    logic [SEL_W:0]    next_hit;
    logic              load;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [SEL_W:0] find_ch(input logic [NUM_CH-1:0] m, input int from);
        logic [SEL_W:0] r;
        r = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (m[k] && (k >= from)) r = {1'b1, SEL_W'(k)};
        end
        return r;
    endfunction

    always_comb begin
        first_hit = find_ch(chan_mask, 0);
        next_hit  = find_ch(mask_q, int'(ch) + 1);
    end

    assign load = (state == ST_DONE) && (!frame_valid || frame_ready);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sel         <= '0;
            ch          <= '0;
            cnt         <= '0;
            mask_q      <= '0;
            shadow      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
        end else begin
            // An accept clears valid; a load later in this block takes precedence.
            if (frame_valid && frame_ready) frame_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    sel <= '0;
                    if (start && (|chan_mask)) begin
                        mask_q <= chan_mask;
                        shadow <= '0;
                        ch     <= first_hit[SEL_W-1:0];
                        sel    <= first_hit[SEL_W-1:0];
                        cnt    <= '0;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CNT_MAX) begin
                        cnt        <= '0;
                        shadow[ch] <= mux_y;
                        if (next_hit[SEL_W]) begin
                            ch  <= next_hit[SEL_W-1:0];
                            sel <= next_hit[SEL_W-1:0];
                        end else begin
                            sel   <= '0;
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    sel <= '0;
                    if (load) begin
                        frame_data  <= shadow;
                        frame_valid <= 1'b1;
                        state       <= ST_IDLE;
                        if (cont_mode) begin
                            mask_q <= chan_mask;
                            if (|chan_mask) begin
                                shadow <= '0;
                                ch     <= first_hit[SEL_W-1:0];
                                sel    <= first_hit[SEL_W-1:0];
                                cnt    <= '0;
                                state  <= ST_SETTLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized bench for mux_scan_ctrl; expected frames are the mux pattern ANDed with the
// channel mask, and expected timing comes from the enabled-channel list.
module tb_mux_scan_ctrl;

    localparam int NUM_CH = 13;
    localparam int SEL_W  = 4;
    localparam int SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              cont_mode = 1'b0;
    logic              frame_ready = 1'b1;
    logic [NUM_CH-1:0] chan_mask = '0;
    logic [SEL_W-1:0]  sel;
    logic              mux_y;
    logic [NUM_CH-1:0] frame_data;
    logic              frame_valid;
    logic              busy;
    logic [15:0]       pat = '0;

    int errors = 0;
    int checks = 0;
    int nacc = 0;
    int sel_over = 0;

    mux_scan_ctrl #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .chan_mask(chan_mask),
        .cont_mode(cont_mode), .sel(sel), .mux_y(mux_y), .frame_data(frame_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy)
    );

    // The mux itself: bit 'sel' of the current test pattern.
    assign mux_y = pat[sel];

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && frame_valid && frame_ready) nacc <= nacc + 1;
    always @(negedge clk) if (rst_n && (int'(sel) > NUM_CH - 1)) sel_over <= sel_over + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // One standalone frame: select sequence, start-to-valid latency, data, accept.
    task automatic run_frame(input string name, input logic [NUM_CH-1:0] m, input logic [15:0] p);
        int en[$];
        int c;
        bit sel_ok;
        logic [NUM_CH-1:0] exp_frame;
        for (int k = 0; k < NUM_CH; k++) if (m[k]) en.push_back(k);
        exp_frame = p[NUM_CH-1:0] & m;
        pat = p; chan_mask = m; cont_mode = 1'b0; frame_ready = 1'b1;
        pulse_start();
        sel_ok = 1'b1;
        c = 1;
        while (c <= en.size() * (SETTLE + 1)) begin
            if (c > 1) @(negedge clk);
            if (sel !== SEL_W'(en[(c - 1) / (SETTLE + 1)]) || busy !== 1'b1) sel_ok = 1'b0;
            c++;
        end
        c--;
        chk({name, "_sel_seq"}, sel_ok, 1);
        do begin
            @(negedge clk);
            c++;
        end while (!frame_valid && c < 200);
        chk({name, "_latency"}, c - 1, en.size() * (SETTLE + 1) + 1);
        chk({name, "_data"}, frame_data, exp_frame);
        @(negedge clk);
        chk({name, "_accepted"}, frame_valid, 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [NUM_CH-1:0] m1, m2, exp1, exp2;
        logic [15:0] p1;
        int n0, guard;
        bit ok;

        #12;
        chk("rst_sel", sel, 0);
        chk("rst_data", frame_data, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;

        run_frame("full", 13'h1FFF, 16'hAAAA);
        run_frame("sparse", 13'h1011, 16'hFFFF);
        for (int i = 0; i < 8; i++) begin
            logic [NUM_CH-1:0] m;
            m = NUM_CH'($urandom);
            if (m == '0) m = 13'h0001;
            run_frame("rand", m, 16'($urandom));
        end

        // Continuous mode with a stalled consumer; mask change mid-scan hits frame 2 only.
        m1 = NUM_CH'($urandom) | 13'h0100;
        m2 = NUM_CH'($urandom) | 13'h0002;
        p1 = 16'($urandom);
        exp1 = p1[NUM_CH-1:0] & m1;
        exp2 = m2;
        pat = p1; chan_mask = m1; cont_mode = 1'b1; frame_ready = 1'b0;
        n0 = nacc;
        pulse_start();
        chan_mask = m2;
        guard = 0;
        while (!frame_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("cont_first_valid", frame_valid, 1);
        pat = 16'hFFFF;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_data !== exp1 || frame_valid !== 1'b1) ok = 1'b0;
        end
        chk("hold_stable", ok, 1);
        chk("stall_busy", busy, 1);
        chk("stall_sel", sel, 0);
        chk("stall_no_accept", nacc, n0);
        cont_mode = 1'b0; frame_ready = 1'b1;
        @(negedge clk);
        chk("swap_valid", frame_valid, 1);
        chk("swap_data", frame_data, exp2);
        chk("swap_count", nacc, n0 + 1);
        @(negedge clk);
        chk("swap_drained", frame_valid, 0);
        chk("swap_idle", busy, 0);
        chk("swap_count2", nacc, n0 + 2);

        // Asynchronous reset in the middle of a scan.
        chan_mask = 13'h1FFF; pat = 16'($urandom);
        pulse_start();
        guard = 0;
        while (sel != 4'd6 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_sel6", sel, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_data", frame_data, 0);
        chk("arst_valid", frame_valid, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (frame_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("arst_no_frame", ok, 1);

        // Start with an empty mask is ignored.
        chan_mask = '0;
        pulse_start();
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0 || sel !== '0) ok = 1'b0;
            @(negedge clk);
        end
        chk("empty_mask_ignored", ok, 1);

        // Start while busy is ignored: exactly one frame results.
        n0 = nacc;
        chan_mask = 13'h00F0; pat = 16'h00A0;
        pulse_start();
        chan_mask = 13'h1FFF;
        repeat (3) @(negedge clk);
        pulse_start();
        repeat (60) @(negedge clk);
        chk("busy_start_frames", nacc, n0 + 1);
        chk("busy_start_data", frame_data, 13'h00A0);
        chk("busy_start_idle", busy, 0);

        chk("sel_range", sel_over, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
